// File: rtl/ser_deserializer.sv
// ---------------------------------------------------------------------------
// ser_deserializer
//
// Collects an MSB-first serial bit stream into a parallel frame. A frame
// starts on the first qualified bit and ends either on the first unqualified
// cycle (gap) or on the cycle that stores bit WIDTH (full). Frames of at
// least MIN_LEN bits are published with a one-cycle valid pulse. Shorter
// frames are dropped with a one-cycle error pulse.
//
// Ports
//   clk_i            : single clock, rising edge
//   rst_ni           : asynchronous active-low reset (released synchronously)
//   ser_data_i       : serial data bit, MSB first
//   ser_data_val_i   : qualifies ser_data_i, one bit per high cycle
//   deser_data_o     : last valid frame, first bit at [WIDTH-1], unused bits 0
//   deser_len_o      : number of valid bits in deser_data_o
//   deser_data_val_o : one-cycle pulse, deser_data_o/deser_len_o just updated
//   err_short_o      : one-cycle pulse, frame shorter than MIN_LEN discarded
//   busy_o           : high while a frame is being received
// ---------------------------------------------------------------------------
module ser_deserializer #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = $clog2(WIDTH + 1),
    parameter int MIN_LEN = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ser_data_i,
    input  logic             ser_data_val_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic [CNT_W-1:0] deser_len_o,
    output logic             deser_data_val_o,
    output logic             err_short_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] TOP_BIT  = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Frame under construction as seen by this edge: a new frame starts
    // from an empty register, so IDLE contributes zeros and count 0.
    logic [WIDTH-1:0] base_data;
    logic [CNT_W-1:0] base_cnt;
    logic [WIDTH-1:0] ins_data;
    logic [CNT_W-1:0] ins_cnt;

    // Termination event and the frame that ends on this edge.
    logic             done;
    logic [WIDTH-1:0] frame_data;
    logic [CNT_W-1:0] frame_len;
    logic             frame_ok;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch
        // is inferred when a branch leaves it untouched.
        base_data  = (state_q == RECV) ? shreg_q : '0;
        base_cnt   = (state_q == RECV) ? cnt_q : '0;
        // One-hot at position WIDTH-1-count; base_cnt < WIDTH here.
        ins_data   = ser_data_i ? (base_data | (TOP_BIT >> base_cnt)) : base_data;
        ins_cnt    = base_cnt + CNT_W'(1);

        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        done       = 1'b0;
        frame_data = shreg_q;
        frame_len  = cnt_q;

        case (state_q)
            IDLE: begin
                if (ser_data_val_i) begin
                    if (ins_cnt == FULL_CNT) begin
                        // Single-bit frames fill the register immediately.
                        done       = 1'b1;
                        frame_data = ins_data;
                        frame_len  = ins_cnt;
                        shreg_d    = '0;
                        cnt_d      = '0;
                    end else begin
                        state_d = RECV;
                        shreg_d = ins_data;
                        cnt_d   = ins_cnt;
                    end
                end
            end
            RECV: begin
                if (ser_data_val_i) begin
                    if (ins_cnt == FULL_CNT) begin
                        // Full termination: the stored bit belongs to this
                        // frame, and the count stops at WIDTH.
                        done       = 1'b1;
                        frame_data = ins_data;
                        frame_len  = ins_cnt;
                        state_d    = IDLE;
                        shreg_d    = '0;
                        cnt_d      = '0;
                    end else begin
                        shreg_d = ins_data;
                        cnt_d   = ins_cnt;
                    end
                end else begin
                    // Gap termination with whatever has been collected.
                    done       = 1'b1;
                    frame_data = shreg_q;
                    frame_len  = cnt_q;
                    state_d    = IDLE;
                    shreg_d    = '0;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase

        frame_ok = (int'(frame_len) >= MIN_LEN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs; data/len only move on an accepted frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deser_data_o     <= '0;
            deser_len_o      <= '0;
            deser_data_val_o <= 1'b0;
            err_short_o      <= 1'b0;
        end else begin
            deser_data_val_o <= done && frame_ok;
            err_short_o      <= done && !frame_ok;
            if (done && frame_ok) begin
                deser_data_o <= frame_data;
                deser_len_o  <= frame_len;
            end
        end
    end

    assign busy_o = (state_q == RECV);

endmodule

// File: tb/tb_ser_deserializer.sv
module tb_ser_deserializer;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam int MIN_LEN = 3;

    logic             clk_i;
    logic             rst_ni;
    logic             ser_data_i;
    logic             ser_data_val_i;
    logic [WIDTH-1:0] deser_data_o;
    logic [CNT_W-1:0] deser_len_o;
    logic             deser_data_val_o;
    logic             err_short_o;
    logic             busy_o;

    ser_deserializer #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .MIN_LEN (MIN_LEN)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_len_o      (deser_len_o),
        .deser_data_val_o (deser_data_val_o),
        .err_short_o      (err_short_o),
        .busy_o           (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: the current frame is a plain queue of bits.
    bit               frame_q[$];
    logic [WIDTH-1:0] exp_data;
    int               exp_len;
    bit               exp_val;
    bit               exp_err;
    bit               exp_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("data",  32'(deser_data_o),     32'(exp_data));
        check("len",   32'(deser_len_o),      32'(exp_len));
        check("val",   32'(deser_data_val_o), 32'(exp_val));
        check("err",   32'(err_short_o),      32'(exp_err));
        check("busy",  32'(busy_o),           32'(exp_busy));
        check("excl",  32'(deser_data_val_o && err_short_o), 32'(0));
    endtask

    task automatic model_reset();
        frame_q.delete();
        exp_data = '0;
        exp_len  = 0;
        exp_val  = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;
    endtask

    task automatic model_terminate();
        if (frame_q.size() >= MIN_LEN) begin
            exp_val  = 1'b1;
            exp_data = '0;
            foreach (frame_q[i]) exp_data[WIDTH-1-i] = frame_q[i];
            exp_len  = frame_q.size();
        end else begin
            exp_err = 1'b1;
        end
        frame_q.delete();
    endtask

    // What the outputs must show after the coming edge with these inputs.
    task automatic model_step(input bit v, input bit b);
        exp_val = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            frame_q.push_back(b);
            if (frame_q.size() == WIDTH) model_terminate();
        end else if (frame_q.size() > 0) begin
            model_terminate();
        end
        exp_busy = (frame_q.size() > 0);
    endtask

    // At each falling edge: check the outputs, then drive the next inputs.
    task automatic cycle(input bit v, input bit b);
        @(negedge clk_i);
        compare_all();
        ser_data_val_i = v;
        ser_data_i     = b;
        model_step(v, b);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i]);
    endtask

    task automatic async_reset();
        #2;
        rst_ni         = 1'b0;
        ser_data_val_i = 1'b0;
        ser_data_i     = 1'b0;
        model_reset();
        #1;
        check("rst_data", 32'(deser_data_o),     32'(0));
        check("rst_len",  32'(deser_len_o),      32'(0));
        check("rst_val",  32'(deser_data_val_o), 32'(0));
        check("rst_err",  32'(err_short_o),      32'(0));
        check("rst_busy", 32'(busy_o),           32'(0));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni         = 1'b0;
        ser_data_i     = 1'b0;
        ser_data_val_i = 1'b0;
        model_reset();
        #1;
        check("por_data", 32'(deser_data_o), 32'(0));
        check("por_busy", 32'(busy_o),       32'(0));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Idle for 20 cycles: nothing moves.
        repeat (20) cycle(1'b0, 1'b0);
        check("idle_busy", 32'(busy_o), 32'(0));

        // 1,0,1,1,0 then gap.
        send_bits(32'b10110, 5);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("f5_data", 32'(deser_data_o),     32'h0000_00B0);
        check("f5_len",  32'(deser_len_o),      32'd5);
        check("f5_val",  32'(deser_data_val_o), 32'd1);
        cycle(1'b0, 1'b0);
        check("f5_pulse_end", 32'(deser_data_val_o), 32'd0);

        // 0xA5 full frame immediately followed by 1,1,1.
        send_bits(32'hA5, 8);
        cycle(1'b1, 1'b1);
        check("a5_data", 32'(deser_data_o),     32'h0000_00A5);
        check("a5_len",  32'(deser_len_o),      32'd8);
        check("a5_val",  32'(deser_data_val_o), 32'd1);
        cycle(1'b1, 1'b1);
        check("e0_busy", 32'(busy_o), 32'd1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("e0_data", 32'(deser_data_o), 32'h0000_00E0);
        check("e0_len",  32'(deser_len_o),  32'd3);
        check("e0_val",  32'(deser_data_val_o), 32'd1);

        // Short frame of 2 bits.
        send_bits(32'b10, 2);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("short_err",  32'(err_short_o),      32'd1);
        check("short_val",  32'(deser_data_val_o), 32'd0);
        check("short_keep", 32'(deser_data_o),     32'h0000_00E0);
        cycle(1'b0, 1'b0);
        check("short_pulse_end", 32'(err_short_o), 32'd0);

        // Reset in the middle of a 4-bit frame.
        send_bits(32'b1011, 4);
        async_reset();
        repeat (3) cycle(1'b0, 1'b0);
        check("post_rst_val", 32'(deser_data_val_o), 32'd0);
        send_bits(32'b110, 3);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("c0_data", 32'(deser_data_o), 32'h0000_00C0);
        check("c0_len",  32'(deser_len_o),  32'd3);

        // Back-to-back 3-bit frames separated by a single gap.
        send_bits(32'b011, 3);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        check("b2b1_data", 32'(deser_data_o),     32'h0000_0060);
        check("b2b1_val",  32'(deser_data_val_o), 32'd1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("b2b2_data", 32'(deser_data_o), 32'h0000_00A0);
        check("b2b2_len",  32'(deser_len_o),  32'd3);
        check("b2b2_val",  32'(deser_data_val_o), 32'd1);

        // Randomized traffic with bursts of various lengths and gaps.
        for (int n = 0; n < 3000; n++) begin
            bit v;
            v = ($urandom_range(0, 99) < 75);
            cycle(v, 1'($urandom));
            if ($urandom_range(0, 999) == 0) async_reset();
        end
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
